// File: rtl/hex_display_ctrl_if.sv
// Bundle of value/control inputs and segment outputs for the hex display controller.
interface hex_display_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value_in;
    logic                    load;
    logic                    lz_en;
    logic [NUM_DIGITS-1:0]   blink_en;
    logic                    lamp_test;
    logic [7*NUM_DIGITS-1:0] hex_out;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic [6:0]              seg_mux;

    modport master (
        output value_in, load, lz_en, blink_en, lamp_test,
        input  hex_out, digit_sel, seg_mux
    );

    modport slave (
        input  value_in, load, lz_en, blink_en, lamp_test,
        output hex_out, digit_sel, seg_mux
    );
endinterface

// File: rtl/hex_display_ctrl.sv
// Multi-digit hex 7-segment controller: registered value, per-digit blink,
// leading-zero blanking, lamp test and a time-multiplexed scan output.
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int BLINK_DIV  = 25000000,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    hex_display_ctrl_if.slave     bus
);
    localparam int BW    = $clog2(BLINK_DIV);
    localparam int SW    = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [SW-1:0]    SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] value_q,     value_d;
    logic [7*NUM_DIGITS-1:0] hex_q,       hex_d;
    logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic [SW-1:0]           scan_cnt_q,  scan_cnt_d;
    logic [IDX_W-1:0]        scan_idx_q,  scan_idx_d;
    logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
    logic [6:0]              seg_mux_c;
    logic [3:0]              dig;
    logic                    lz_run;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        value_d = bus.load ? bus.value_in : value_q;

        blink_cnt_d   = blink_cnt_q + BW'(1);
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end

        scan_cnt_d = scan_cnt_q + SW'(1);
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IDX_W'(1);
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_sel_d[i] = (scan_idx_d == IDX_W'(i));
        end
    end

    // Walk from the most significant digit down so lz_run means "this and all higher digits are zero".
    always_comb begin
        hex_d  = '1;
        lz_run = 1'b1;
        dig    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            dig    = value_q[4*i +: 4];
            lz_run = lz_run & (dig == 4'h0);
            if (bus.lamp_test)
                hex_d[7*i +: 7] = 7'h00;
            else if (bus.blink_en[i] && blink_phase_q)
                hex_d[7*i +: 7] = 7'h7F;
            else if (bus.lz_en && lz_run && (i != 0))
                hex_d[7*i +: 7] = 7'h7F;
            else
                hex_d[7*i +: 7] = decode(dig);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q       <= '0;
            hex_q         <= '1;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            scan_cnt_q    <= '0;
            scan_idx_q    <= '0;
            digit_sel_q   <= NUM_DIGITS'(1);
        end else begin
            value_q       <= value_d;
            hex_q         <= hex_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            scan_cnt_q    <= scan_cnt_d;
            scan_idx_q    <= scan_idx_d;
            digit_sel_q   <= digit_sel_d;
        end
    end

    always_comb begin
        seg_mux_c = 7'h7F;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx_q == IDX_W'(i))
                seg_mux_c = hex_q[7*i +: 7];
        end
    end

    assign bus.hex_out   = hex_q;
    assign bus.digit_sel = digit_sel_q;
    assign bus.seg_mux   = seg_mux_c;
endmodule

// File: tb/tb_hex_display_ctrl.sv
// Randomized bench for hex_display_ctrl against a cycle-count based reference model.
module tb_hex_display_ctrl;
    localparam int NUM_DIGITS = 4;
    localparam int BLINK_DIV  = 4;
    localparam int SCAN_DIV   = 3;

    logic clk = 1'b0;
    logic rst;

    hex_display_ctrl_if #(.NUM_DIGITS(NUM_DIGITS)) hif ();

    hex_display_ctrl #(
        .NUM_DIGITS(NUM_DIGITS),
        .BLINK_DIV (BLINK_DIV),
        .SCAN_DIV  (SCAN_DIV)
    ) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (hif.slave)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [6:0]  seg_tab [16];
    logic [27:0] m_hex;
    int unsigned m_value;
    int          m_n;

    // Reference: phase and scan position follow directly from edges elapsed since reset.
    function automatic bit model_phase(int n);
        return ((n / BLINK_DIV) % 2) == 1;
    endfunction

    function automatic int model_idx(int n);
        return (n / SCAN_DIV) % NUM_DIGITS;
    endfunction

    function automatic logic [27:0] model_hex(int unsigned v, bit ph, bit lz,
                                              logic [3:0] bl, bit lt);
        logic [27:0] r;
        int unsigned d;
        r = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d = (v >> (4*i)) & 15;
            if (lt)
                r[7*i +: 7] = 7'h00;
            else if (bl[i] && ph)
                r[7*i +: 7] = 7'h7F;
            else if (lz && i > 0 && (v >> (4*i)) == 0)
                r[7*i +: 7] = 7'h7F;
            else
                r[7*i +: 7] = seg_tab[d];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_hex   = '1;
            m_value = 0;
            m_n     = 0;
        end else begin
            m_hex = model_hex(m_value, model_phase(m_n), hif.lz_en, hif.blink_en, hif.lamp_test);
            if (hif.load) m_value = 32'(hif.value_in);
            m_n++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        int idx;
        logic [31:0] sel_exp;
        @(posedge clk);
        @(negedge clk);
        idx     = model_idx(m_n);
        sel_exp = 32'd1 << idx;
        check_val("hex", 32'(hif.hex_out), 32'(m_hex));
        check_val("sel", 32'(hif.digit_sel), sel_exp);
        check_val("seg", 32'(hif.seg_mux), 32'((m_hex >> (7*idx)) & 28'h7F));
    endtask

    task automatic load_val(input logic [15:0] v);
        hif.value_in = v;
        hif.load     = 1'b1;
        tick();
        hif.load     = 1'b0;
        tick();
    endtask

    initial begin
        bit found;
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        rst           = 1'b1;
        hif.value_in  = '0;
        hif.load      = 1'b0;
        hif.lz_en     = 1'b0;
        hif.blink_en  = '0;
        hif.lamp_test = 1'b0;
        tick();
        tick();
        check_val("rst_hex", 32'(hif.hex_out), 32'h0FFFFFFF);
        check_val("rst_sel", 32'(hif.digit_sel), 32'h1);
        check_val("rst_seg", 32'(hif.seg_mux), 32'h7F);

        rst = 1'b0;
        tick();
        check_val("init_0000", 32'(hif.hex_out), 32'({7'h40, 7'h40, 7'h40, 7'h40}));

        load_val(16'h1A2F);
        check_val("ld_1A2F", 32'(hif.hex_out), 32'({7'h79, 7'h08, 7'h24, 7'h0E}));
        repeat (3) tick();
        check_val("hold_1A2F", 32'(hif.hex_out), 32'({7'h79, 7'h08, 7'h24, 7'h0E}));

        hif.lz_en = 1'b1;
        load_val(16'h00B0);
        check_val("lz_00B0", 32'(hif.hex_out), 32'({7'h7F, 7'h7F, 7'h03, 7'h40}));
        load_val(16'h0000);
        check_val("lz_0000", 32'(hif.hex_out), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
        hif.lz_en = 1'b0;

        hif.blink_en = 4'b0010;
        load_val(16'h1234);
        repeat (16) tick();

        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (model_phase(m_n)) found = 1'b1;
            else tick();
        end
        check_val("find_off", 32'(found), 32'd1);
        hif.lamp_test = 1'b1;
        tick();
        check_val("lamp", 32'(hif.hex_out), 32'h0);
        hif.value_in = 16'hBEEF;
        hif.load     = 1'b1;
        tick();
        hif.load     = 1'b0;
        tick();
        check_val("lamp_ld", 32'(hif.hex_out), 32'h0);
        hif.lamp_test = 1'b0;
        repeat (24) tick();

        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (model_phase(m_n) && model_idx(m_n) == 2) found = 1'b1;
            else tick();
        end
        check_val("find_rst", 32'(found), 32'd1);
        rst = 1'b1;
        tick();
        check_val("mid_rst_hex", 32'(hif.hex_out), 32'h0FFFFFFF);
        check_val("mid_rst_sel", 32'(hif.digit_sel), 32'h1);
        rst = 1'b0;
        tick();
        check_val("post_rst", 32'(hif.hex_out), 32'({7'h40, 7'h40, 7'h40, 7'h40}));

        for (int k = 0; k < 400; k++) begin
            hif.value_in  = 16'($urandom);
            hif.load      = ($urandom_range(0, 3) == 0);
            hif.lz_en     = 1'($urandom);
            hif.blink_en  = 4'($urandom);
            hif.lamp_test = ($urandom_range(0, 15) == 0);
            rst           = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 2) == 0) hif.value_in[15:8] = 8'h00;
            if ($urandom_range(0, 3) == 0) hif.value_in[7:4]  = 4'h0;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
- Parametrised multi-digit hexadecimal 7-segment display controller; successor to the single-digit combinational decoder.
- Registers a packed hex value on a load strobe and decodes every digit to an active-low segment pattern.
- Adds per-digit blink, leading-zero suppression, lamp test, and a time-multiplexed scan output for boards with shared segment lines.
- Sits between datapath or switch logic and the board HEX displays.

Parameters:
NUM_DIGITS, 4, number of hex digits driven (legal 1..8)
BLINK_DIV, 25000000, clk cycles per blink half-period (legal >= 2)
SCAN_DIV, 50000, clk cycles each digit is held selected on the scan outputs (legal >= 2)

Ports:
clk  input  1  system clock; all state on its rising edge
reset  input  1  synchronous, active-high reset
value_in  input  4*NUM_DIGITS  packed value; digit i = value_in[4i+3:4i]
load  input  1  capture value_in into value_reg when high
lz_en  input  1  leading-zero suppression enable
blink_en  input  NUM_DIGITS  per-digit blink enable; bit i controls digit i
lamp_test  input  1  force all segments lit
hex_out  output  7*NUM_DIGITS  registered parallel segments, digit i = hex_out[7i+6:7i]; bit0=a … bit6=g; active-low
digit_sel  output  NUM_DIGITS  registered one-hot scan select, active-high
seg_mux  output  7  segments of the currently selected digit, active-low

Behaviour:
- Reset, synchronous, overrides all other inputs: value_reg=0, hex_out=all 1 (every digit 7'h7F, dark), blink counter=0, blink_phase=0 (visible), scan counter=0, scan_idx=0, digit_sel=1, seg_mux=7'h7F.
- Load: load=1 sampled at edge k writes value_reg at edge k; hex_out reflects the new value at edge k+1. Total latency is 2 edges from load to display. load=0 holds value_reg.
- Decode (g..a, hex) for digits 0–F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E. Blank pattern = 7F.
- Per-digit pattern priority, evaluated from the current value_reg, blink_phase and control inputs, then registered into hex_out every cycle:
  1. lamp_test=1 → 7'h00.
  2. Else blink_en[i]=1 and blink_phase=1 → 7F.
  3. Else lz_en=1 and digit i is a leading zero → 7F.
  4. Else decode(digit i).
- Leading-zero definition: digit i, for i>0, is a leading zero if it and every higher digit equal 0. Digit 0 is never suppressed, so value 0 displays a single "0".
- Control inputs lz_en, blink_en and lamp_test take effect on hex_out one edge after they are sampled.
- Blink counter: counts 0..BLINK_DIV-1 and wraps to 0. On the wrap edge, blink_phase toggles. It free-runs and is not restarted by load.
- Scan counter: counts 0..SCAN_DIV-1. On the wrap edge, scan_idx increments, wrapping NUM_DIGITS-1 → 0. digit_sel is registered as one-hot(scan_idx). For NUM_DIGITS=1, digit_sel stays 1.
- seg_mux = hex_out[7*scan_idx +: 7], combinational from registered state. It is therefore always consistent with digit_sel and hex_out in the same cycle.
- Reset asserted mid-blink or mid-scan: every counter and phase returns to its reset value on that edge, and the display goes dark for that cycle.
- load and lamp_test high together: value_reg is still captured; lamp test controls the display until it is released.

Test Plan:
- Bench configuration: NUM_DIGITS=4, BLINK_DIV=4, SCAN_DIV=3.
- Reset then idle → hex_out=28'hFFFFFFF, digit_sel=4'b0001, seg_mux=7'h7F. After the first post-reset edge with reset low and no load: hex_out shows "0000" (each digit 7'h40).
- load=1 with value_in=16'h1A2F for 1 cycle → 2 edges later hex_out digits 3..0 = 79,08,24,0E; they hold after load drops.
- lz_en=1, load value 16'h00B0 → digits 3,2 = 7F; digits 1,0 = 03,40. Load 16'h0000 → digits 3..1 = 7F, digit 0 = 40.
- blink_en=4'b0010 with value 16'h1234 → digit 1 alternates 30/7F every 4 cycles; digits 3,2,0 stay steady at 79,24,19. Raising lamp_test during the off phase → all digits 00 on the next edge.
- Scan check → digit_sel steps 0001→0010→0100→1000→0001, each held 3 cycles; seg_mux equals the matching hex_out slice every cycle.
- Assert reset mid-blink off-phase with scan_idx=2 → next edge: dark display, digit_sel=0001, blink restarts in visible phase; value_reg=0.
